// File: rtl/obstacle_manager_if.sv
`default_nettype none
// ============================================================================
// Module   : obstacle_manager_if
// Purpose  : Game-control / obstacle-state bundle for obstacle_manager.
//            master = game controller side, slave = obstacle_manager side.
// Signals  : game_start  - one-cycle restart pulse (master -> slave)
//            game_frozen - level, suppresses all ticks (master -> slave)
//            game_tick   - one-cycle 60 Hz motion pulse (master -> slave)
//            rng         - free-running random byte (master -> slave)
//            obs_pos     - packed slot x-positions, W bits per slot
//            obs_type    - packed slot sprite types, 3 bits per slot
//            obs_active  - per-slot active flag
//            speed       - current pixels-per-tick
// Revision : 1.0 - initial release
// ============================================================================
interface obstacle_manager_if #(
  parameter int NUM_SLOTS = 2,
  parameter int W         = 8
);
  logic                   game_start;
  logic                   game_frozen;
  logic                   game_tick;
  logic [7:0]             rng;
  logic [NUM_SLOTS*W-1:0] obs_pos;
  logic [NUM_SLOTS*3-1:0] obs_type;
  logic [NUM_SLOTS-1:0]   obs_active;
  logic [2:0]             speed;

  modport master (
    output game_start, game_frozen, game_tick, rng,
    input  obs_pos, obs_type, obs_active, speed
  );

  modport slave (
    input  game_start, game_frozen, game_tick, rng,
    output obs_pos, obs_type, obs_active, speed
  );
endinterface
`default_nettype wire

// File: rtl/obstacle_manager.sv
`default_nettype none
// ============================================================================
// Module   : obstacle_manager
// Purpose  : Manages NUM_SLOTS scrolling obstacles: spawns at SPAWN_X with a
//            random gap, moves active slots left by speed on every unfrozen
//            tick, retires slots that leave the screen, and ramps speed.
// Ports    : clk - clock
//            rst - asynchronous active-high reset
//            bus - obstacle_manager_if.slave (game controls in, obstacle
//                  state out; all outputs come straight from registers)
// Revision : 1.0 - initial release
// ============================================================================
module obstacle_manager #(
  parameter int NUM_SLOTS  = 2,
  parameter int CONV       = 2,
  parameter int SPAWN_X    = 159,
  parameter int MIN_GAP    = 40,
  parameter int SPEED_MAX  = 4,
  parameter int RAMP_TICKS = 600
) (
  input  logic               clk,
  input  logic               rst,
  obstacle_manager_if.slave  bus
);
  localparam int W  = 10 - CONV;
  localparam int RW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;

  localparam logic [W-1:0]  c_spawn_x   = SPAWN_X[W-1:0];
  localparam logic [10:0]   c_spawn_x11 = SPAWN_X[10:0];
  localparam logic [9:0]    c_min_gap   = MIN_GAP[9:0];
  localparam logic [2:0]    c_speed_max = SPEED_MAX[2:0];
  localparam logic [RW-1:0] c_ramp_last = RW'(RAMP_TICKS - 1);

  logic [W-1:0]  r_pos  [NUM_SLOTS];
  logic [2:0]    r_type [NUM_SLOTS];
  logic          r_act  [NUM_SLOTS];
  logic [2:0]    r_speed;
  logic [RW-1:0] r_ramp;
  logic [9:0]    r_gap;

  logic                 w_adv;
  logic [NUM_SLOTS-1:0] w_active;
  logic [NUM_SLOTS-1:0] w_spawn_sel;
  logic [W-1:0]         w_max_pos;
  logic                 w_spawn_ok;

  // Only an unfrozen tick without a coincident restart moves anything.
  assign w_adv = bus.game_tick & ~bus.game_frozen & ~bus.game_start;

  // Spawn decision looks at pre-advance state only, so a slot retiring on
  // this advance is still seen as active and cannot be reused until the next.
  always_comb begin
    w_max_pos = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_active[i] = r_act[i];
      if (r_act[i] && (r_pos[i] > w_max_pos)) begin
        w_max_pos = r_pos[i];
      end
    end
  end

  // Lowest clear bit of w_active; all-zero when every slot is busy, which
  // defers the spawn to a later advance without overwriting anything.
  assign w_spawn_sel = ~w_active & (w_active + 1'b1);

  // max_pos + gap <= SPAWN_X, widened so a large gap cannot underflow.
  assign w_spawn_ok = (w_active == '0) ||
                      ((11'(w_max_pos) + 11'(r_gap)) <= c_spawn_x11);

  generate
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_act[i]  <= 1'b0;
          r_pos[i]  <= c_spawn_x;
          r_type[i] <= 3'd0;
        end else if (bus.game_start) begin
          r_act[i]  <= 1'b0;
          r_pos[i]  <= c_spawn_x;
        end else if (w_adv) begin
          if (w_spawn_sel[i] && w_spawn_ok) begin
            // Fresh spawn stays at SPAWN_X for this advance.
            r_act[i]  <= 1'b1;
            r_pos[i]  <= c_spawn_x;
            r_type[i] <= bus.rng[7:5];
          end else if (r_act[i]) begin
            if (r_pos[i] < W'(r_speed)) begin
              r_act[i] <= 1'b0;
              r_pos[i] <= c_spawn_x;
            end else begin
              r_pos[i] <= r_pos[i] - W'(r_speed);
            end
          end
        end
      end

      assign bus.obs_pos[i*W +: W]  = r_pos[i];
      assign bus.obs_type[i*3 +: 3] = r_type[i];
    end
  endgenerate

  // Speed ramp and spawn gap. Motion above uses the pre-advance speed, so a
  // speed increment is first applied on the following advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_speed <= 3'd1;
      r_ramp  <= '0;
      r_gap   <= c_min_gap;
    end else if (bus.game_start) begin
      r_speed <= 3'd1;
      r_ramp  <= '0;
      r_gap   <= c_min_gap;
    end else if (w_adv) begin
      if (r_ramp == c_ramp_last) begin
        r_ramp <= '0;
        if (r_speed < c_speed_max) begin
          r_speed <= r_speed + 3'd1;
        end
      end else begin
        r_ramp <= r_ramp + 1'b1;
      end
      if (w_spawn_ok && (w_spawn_sel != '0)) begin
        r_gap <= c_min_gap + 10'(bus.rng[4:0]);
      end
    end
  end

  assign bus.obs_active = w_active;
  assign bus.speed      = r_speed;
endmodule
`default_nettype wire

// File: tb/tb_obstacle_manager.sv
`default_nettype none
// ============================================================================
// Module   : tb_obstacle_manager
// Purpose  : Self-checking bench for obstacle_manager: directed scenarios
//            plus randomized control traffic against a slot-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_obstacle_manager;
  localparam int NS   = 2;
  localparam int W    = 8;
  localparam int SPX  = 159;
  localparam int MG   = 40;
  localparam int SMAX = 4;
  localparam int RT   = 600;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  obstacle_manager_if #(.NUM_SLOTS(NS), .W(W)) bus ();

  obstacle_manager #(
    .NUM_SLOTS(NS), .CONV(2), .SPAWN_X(SPX), .MIN_GAP(MG),
    .SPEED_MAX(SMAX), .RAMP_TICKS(RT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model state
  int m_pos  [NS];
  int m_type [NS];
  bit m_act  [NS];
  int m_speed;
  int m_adv;
  int m_gap;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input bit clear_type);
    for (int i = 0; i < NS; i++) begin
      m_act[i] = 1'b0;
      m_pos[i] = SPX;
      if (clear_type) m_type[i] = 0;
    end
    m_speed = 1;
    m_adv   = 0;
    m_gap   = MG;
  endtask

  task automatic model_step(input bit start, input bit frozen, input bit tick, input int r);
    bit any;
    int maxp;
    bit ok;
    int slot;
    if (start) begin
      model_clear(1'b0);
    end else if (tick && !frozen) begin
      any  = 1'b0;
      maxp = 0;
      slot = -1;
      for (int i = 0; i < NS; i++) begin
        if (m_act[i]) begin
          any = 1'b1;
          if (m_pos[i] > maxp) maxp = m_pos[i];
        end else if (slot < 0) begin
          slot = i;
        end
      end
      ok = !any || (maxp + m_gap <= SPX);
      for (int i = 0; i < NS; i++) begin
        if (m_act[i]) begin
          if (m_pos[i] < m_speed) begin
            m_act[i] = 1'b0;
            m_pos[i] = SPX;
          end else begin
            m_pos[i] = m_pos[i] - m_speed;
          end
        end
      end
      if (ok && slot >= 0) begin
        m_act[slot]  = 1'b1;
        m_pos[slot]  = SPX;
        m_type[slot] = (r >> 5) & 7;
        m_gap        = MG + (r & 31);
      end
      m_adv++;
      if ((m_adv % RT) == 0 && m_speed < SMAX) m_speed++;
    end
  endtask

  task automatic compare_all(input string tag);
    logic [NS*W-1:0] ep;
    logic [NS*3-1:0] et;
    logic [NS-1:0]   ea;
    for (int i = 0; i < NS; i++) begin
      ep[i*W +: W] = W'(m_pos[i]);
      et[i*3 +: 3] = 3'(m_type[i]);
      ea[i]        = m_act[i];
    end
    check_eq({tag, "_pos"},    32'(bus.obs_pos),    32'(ep));
    check_eq({tag, "_type"},   32'(bus.obs_type),   32'(et));
    check_eq({tag, "_active"}, 32'(bus.obs_active), 32'(ea));
    check_eq({tag, "_speed"},  32'(bus.speed),      32'(m_speed));
  endtask

  // One clock: drive after the falling edge, check at the next falling edge.
  task automatic cyc(input bit start, input bit frozen, input bit tick, input int r, input string tag);
    bus.game_start  = start;
    bus.game_frozen = frozen;
    bus.game_tick   = tick;
    bus.rng         = r[7:0];
    @(posedge clk);
    model_step(start, frozen, tick, r & 255);
    @(negedge clk);
    compare_all(tag);
  endtask

  initial begin
    int guard;
    logic [NS*W-1:0] snap_pos;
    logic [NS-1:0]   snap_act;
    rst             = 1'b1;
    bus.game_start  = 1'b0;
    bus.game_frozen = 1'b0;
    bus.game_tick   = 1'b0;
    bus.rng         = 8'h00;
    model_clear(1'b1);
    repeat (2) @(negedge clk);
    compare_all("reset");
    rst = 1'b0;

    // Idle after reset: no spawn without an advance
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, int'($urandom_range(255)), "idle");
    check_eq("idle_active", 32'(bus.obs_active), 32'd0);

    // First spawn with rng = A0
    cyc(1'b1, 1'b0, 1'b0, 8'hA0, "start");
    cyc(1'b0, 1'b0, 1'b1, 8'hA0, "spawn1");
    check_eq("spawn1_act0", 32'(bus.obs_active[0]), 32'd1);
    check_eq("spawn1_pos0", 32'(bus.obs_pos[W-1:0]), 32'd159);
    check_eq("spawn1_type0", 32'(bus.obs_type[2:0]), 32'd5);
    cyc(1'b0, 1'b0, 1'b1, 8'hA0, "move1");
    check_eq("move1_pos0", 32'(bus.obs_pos[W-1:0]), 32'd158);

    // Gap with rng = 0: second slot spawns on tick 42
    cyc(1'b1, 1'b0, 1'b0, 0, "start2");
    for (int k = 1; k <= 41; k++) cyc(1'b0, 1'b0, 1'b1, 0, "gap");
    check_eq("gap41_pos0", 32'(bus.obs_pos[W-1:0]), 32'd119);
    check_eq("gap41_active", 32'(bus.obs_active), 32'b01);
    cyc(1'b0, 1'b0, 1'b1, 0, "gap42");
    check_eq("gap42_active", 32'(bus.obs_active), 32'b11);
    check_eq("gap42_pos0", 32'(bus.obs_pos[W-1:0]), 32'd118);
    check_eq("gap42_pos1", 32'(bus.obs_pos[2*W-1:W]), 32'd159);
    cyc(1'b0, 1'b0, 1'b1, 0, "gap43");
    check_eq("gap43_pos0", 32'(bus.obs_pos[W-1:0]), 32'd117);
    check_eq("gap43_pos1", 32'(bus.obs_pos[2*W-1:W]), 32'd158);

    // Run slot0 down to pos 1 with both slots busy (spawn deferred)
    guard = 0;
    while (!(m_act[0] && m_pos[0] == 1) && guard < 300) begin
      cyc(1'b0, 1'b0, 1'b1, 0, "run");
      guard++;
    end
    check_eq("run_reached", 32'(guard < 300), 32'd1);
    check_eq("full_active", 32'(bus.obs_active), 32'b11);
    check_eq("full_pos1", 32'(bus.obs_pos[2*W-1:W]), 32'd42);
    cyc(1'b0, 1'b0, 1'b1, 0, "exit0");
    check_eq("exit0_pos0", 32'(bus.obs_pos[W-1:0]), 32'd0);
    check_eq("exit0_act", 32'(bus.obs_active), 32'b11);
    cyc(1'b0, 1'b0, 1'b1, 0, "exit1");
    check_eq("exit1_act", 32'(bus.obs_active), 32'b10);
    check_eq("exit1_pos0", 32'(bus.obs_pos[W-1:0]), 32'd159);
    cyc(1'b0, 1'b0, 1'b1, 8'h60, "respawn");
    check_eq("respawn_act", 32'(bus.obs_active), 32'b11);
    check_eq("respawn_type0", 32'(bus.obs_type[2:0]), 32'd3);

    // Freeze holds everything
    snap_pos = bus.obs_pos;
    snap_act = bus.obs_active;
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, 1'b1, int'($urandom_range(255)), "frozen");
    check_eq("frozen_pos", 32'(bus.obs_pos), 32'(snap_pos));
    check_eq("frozen_act", 32'(bus.obs_active), 32'(snap_act));
    cyc(1'b0, 1'b0, 1'b1, 0, "thaw");

    // Randomized control traffic
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom_range(199) == 0), ($urandom_range(7) == 0),
          ($urandom_range(1) == 1), int'($urandom_range(255)), "rand");
    end

    // Asynchronous reset mid-game, no clock edge in between
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b1, int'($urandom_range(255)), "pre_rst");
    #2 rst = 1'b1;
    #1;
    check_eq("arst_active", 32'(bus.obs_active), 32'd0);
    check_eq("arst_pos", 32'(bus.obs_pos), 32'({NS{8'd159}}));
    check_eq("arst_speed", 32'(bus.speed), 32'd1);
    check_eq("arst_type", 32'(bus.obs_type), 32'd0);
    model_clear(1'b1);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 0, "post_rst");

    // Speed ramp over 2400 consecutive advances
    cyc(1'b1, 1'b0, 1'b0, 0, "ramp_start");
    for (int n = 1; n <= 2400; n++) begin
      cyc(1'b0, 1'b0, 1'b1, int'($urandom_range(255)), "ramp");
      if (n == 599)  check_eq("ramp599_speed",  32'(bus.speed), 32'd1);
      if (n == 600)  check_eq("ramp600_speed",  32'(bus.speed), 32'd2);
      if (n == 1200) check_eq("ramp1200_speed", 32'(bus.speed), 32'd3);
      if (n == 1800) check_eq("ramp1800_speed", 32'(bus.speed), 32'd4);
      if (n == 2400) check_eq("ramp2400_speed", 32'(bus.speed), 32'd4);
    end

    // Restart coincident with tick and freeze
    cyc(1'b1, 1'b1, 1'b1, int'($urandom_range(255)), "restart");
    check_eq("restart_speed", 32'(bus.speed), 32'd1);
    check_eq("restart_active", 32'(bus.obs_active), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 8'h20, "restart_spawn");
    check_eq("restart_spawn_act", 32'(bus.obs_active), 32'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
